upp_frame_checker: RTL and testbench
====================================

Name: upp_frame_checker

Overview:
- Receive-side monitor on the uPP output of the BLVDS-to-uPP bridge: samples the 16-bit uPP word bus and its ENA strobe, and checks every frame it sees.
- Validates header, sequence number, length and checksum; counts good and bad frames; flags link silence.
- Drives pulses, flags and counters to SignalTap II and the board debug LEDs.
- Runs on the same PLL clock that launches uPP data (70 MHz phase-shifted output).

Parameters:
- SYNC_WORD, 16'hF5F5, required value of word 0 of every frame.
- FRAME_LEN, 16'd36, required total words per frame, including header, sequence and checksum words.
- TIMEOUT_CYC, 32'd70000000, idle cycles without a frame start before oTIMEOUT asserts (1 s at 70 MHz).

Ports:
- iCLK  in  1  uPP sampling clock.
- iRESET_N  in  1  synchronous, active-low reset.
- iDATA_UPP  in  16  uPP data word; valid only when iENA=1.
- iENA  in  1  uPP enable; a frame is one contiguous run of iENA=1 cycles.
- oFRAME_OK  out  1  one-cycle pulse: the frame just ended passed all checks.
- oFRAME_ERR  out  1  one-cycle pulse: the frame just ended failed at least one check.
- oERR_CODE  out  4  error flags of the last completed frame. bit0 header, bit1 sequence, bit2 length, bit3 checksum.
- oLAST_LEN  out  16  word count of the last completed frame.
- oFRAME_CNT  out  16  completed frames since reset; wraps at 16'hFFFF.
- oERR_CNT  out  16  failed frames since reset; saturates at 16'hFFFF.
- oTIMEOUT  out  1  level: no frame start for TIMEOUT_CYC cycles.

Behaviour:
- Reset (iRESET_N=0 sampled at a rising iCLK edge):
  - All outputs, counters and the running checksum go to 0.
  - State goes to WAIT_LOW; the sequence reference is marked invalid.
- Frame format: word0 = SYNC_WORD; word1 = sequence number; words 2..N-2 = payload; word N-1 = 16-bit checksum, the mod-2^16 sum of words 0..N-2.
- States:
  - WAIT_LOW: ignore all input. Go to IDLE on the first iENA=0 sample. A frame already in progress when reset is released is discarded.
  - IDLE: iENA=1 -> RUN. That first word is captured as word0, the word counter is set to 1, and the timeout counter is cleared.
  - RUN, iENA=1: capture the word. Word counter increments and saturates at 16'hFFFF. Track sum_prev (sum of all words before the current one) and last_word.
  - RUN, iENA=0: end of frame; evaluate and go to IDLE. The result is registered and becomes visible on the next cycle.
- End-of-frame latency: oFRAME_OK/oFRAME_ERR, oERR_CODE, oLAST_LEN and the counters update one cycle after the first iENA=0 sample.
- Back-to-back frames: a single iENA=0 cycle between frames is legal. If iENA returns high in the cycle the result is published, the new frame is captured normally.
- Check rules:
  - header: word0 != SYNC_WORD.
  - length: word count != FRAME_LEN.
  - checksum: last_word != sum_prev. Checked only if count >= 3, otherwise this bit is 0.
  - sequence: word1 != expected. Checked only if count >= 2 and the reference is valid.
- Sequence reference update: after any frame with count >= 2, expected = word1 + 1 (mod 2^16) and the reference becomes valid, even when the frame failed. This resynchronises the check.
  - The first frame after reset never raises a sequence error.
  - Sequence 16'hFFFF followed by 16'h0000 is legal.
- Result outputs:
  - oERR_CODE != 0 -> oFRAME_ERR pulse and oERR_CNT increments; otherwise oFRAME_OK pulse.
  - oFRAME_CNT increments on every completed frame.
  - oERR_CODE and oLAST_LEN hold until the next completed frame.
- Timeout counter:
  - Counts in IDLE and WAIT_LOW; saturates at TIMEOUT_CYC.
  - oTIMEOUT=1 while the counter equals TIMEOUT_CYC.
  - The counter clears, and oTIMEOUT drops, in the cycle a frame starts.
- Reset taking effect mid-frame: the partial frame is dropped, with no pulse and no count.

Decomposition:
- Shared package/include upp_frame_pkg holds:
  - the default SYNC_WORD;
  - the ERR_HDR/ERR_SEQ/ERR_LEN/ERR_CSUM bit indices;
  - the state encodings WAIT_LOW/IDLE/RUN.
- One sub-module is natural: upp_sat_cnt, a parameterised-width saturating counter with synchronous clear. It is used for the word count, oERR_CNT and the timeout counter.

Test Plan:
- Frame F5F5,0001, 33 payload words of 0001, checksum 16'hF617 (=F5F5+0001+33·0001) -> 1 cycle after ENA low: oFRAME_OK=1, oERR_CODE=0, oLAST_LEN=36, oFRAME_CNT=1.
- Two good frames with seq 0005 then 0007 -> second frame: oFRAME_ERR=1, oERR_CODE=4'b0010, oERR_CNT=1. A third frame with seq 0008 -> oFRAME_OK.
- Good frame plus one extra word (37 words, checksum placed at word 36) -> oERR_CODE=4'b0100. Header 16'hF5F4 with a correct checksum -> 4'b0001. Corrupted checksum -> 4'b1000.
- Seq FFFF then 0000 with one-cycle ENA gap -> both frames OK, both pulses seen, oFRAME_CNT=2.
- Reset released while iENA=1 mid-frame -> no pulse for that frame; the next full frame gives oFRAME_OK and no sequence error.
- TIMEOUT_CYC=100, no traffic -> oTIMEOUT=1 from the 100th post-reset cycle; next frame start clears it the same cycle.

Source files
------------

// File: rtl/upp_frame_pkg.sv
// Shared constants for the uPP receive-side frame checker: default sync word,
// error flag bit positions and the checker state encoding.
package upp_frame_pkg;

  localparam logic [15:0] SYNC_WORD_DEF = 16'hF5F5;

  localparam int ERR_HDR  = 0;
  localparam int ERR_SEQ  = 1;
  localparam int ERR_LEN  = 2;
  localparam int ERR_CSUM = 3;

  typedef enum logic [1:0] {
    WAIT_LOW = 2'd0,
    IDLE     = 2'd1,
    RUN      = 2'd2
  } state_t;

endpackage

// File: rtl/upp_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear together with increment
// loads 1 so a counter can restart on the same cycle it counts the first event.
module upp_sat_cnt #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] MAX   = '1
) (
  input  logic             iCLK,
  input  logic             iRESET_N,
  input  logic             iCLR,
  input  logic             iINC,
  output logic [WIDTH-1:0] oQ
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] r_q;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its inputs, independent of statement order.
  always_ff @(posedge iCLK) begin
    if (!iRESET_N) begin
      r_q <= '0;
    end else if (iCLR) begin
      r_q <= iINC ? ONE : '0;
    end else if (iINC && (r_q != MAX)) begin
      r_q <= r_q + ONE;
    end
  end

  assign oQ = r_q;

endmodule

// File: rtl/upp_frame_checker.sv
// Receive-side uPP frame monitor: checks header, sequence, length and checksum
// of every contiguous iENA burst, publishes results and counts, flags silence.
module upp_frame_checker
  import upp_frame_pkg::*;
#(
  parameter logic [15:0] SYNC_WORD   = SYNC_WORD_DEF,
  parameter logic [15:0] FRAME_LEN   = 16'd36,
  parameter logic [31:0] TIMEOUT_CYC = 32'd70000000
) (
  input  logic        iCLK,
  input  logic        iRESET_N,
  input  logic [15:0] iDATA_UPP,
  input  logic        iENA,
  output logic        oFRAME_OK,
  output logic        oFRAME_ERR,
  output logic [3:0]  oERR_CODE,
  output logic [15:0] oLAST_LEN,
  output logic [15:0] oFRAME_CNT,
  output logic [15:0] oERR_CNT,
  output logic        oTIMEOUT
);

  state_t r_state;
  state_t w_next;

  logic        w_start;
  logic        w_capture;
  logic        w_eval;
  logic [15:0] w_word_cnt;
  logic [31:0] w_to_cnt;
  logic [3:0]  w_err_code;

  logic [15:0] r_word0;
  logic [15:0] r_word1;
  logic [15:0] r_sum;
  logic [15:0] r_sum_prev;
  logic [15:0] r_last_word;
  logic [15:0] r_seq_exp;
  logic        r_seq_valid;
  logic        r_frame_ok;
  logic        r_frame_err;
  logic [3:0]  r_err_code;
  logic [15:0] r_last_len;
  logic [15:0] r_frame_cnt;

  assign w_start   = (r_state == IDLE) && iENA;
  assign w_capture = (r_state == RUN) && iENA;
  assign w_eval    = (r_state == RUN) && !iENA;

  always_ff @(posedge iCLK) begin
    if (!iRESET_N) r_state <= WAIT_LOW;
    else           r_state <= w_next;
  end

  // NOTE: every always_comb output gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      WAIT_LOW: if (!iENA) w_next = IDLE;
      IDLE:     if (iENA)  w_next = RUN;
      RUN:      if (!iENA) w_next = IDLE;
      default:  w_next = WAIT_LOW;
    endcase
  end

  always_comb begin
    w_err_code           = 4'b0000;
    w_err_code[ERR_HDR]  = (r_word0 != SYNC_WORD);
    w_err_code[ERR_LEN]  = (w_word_cnt != FRAME_LEN);
    w_err_code[ERR_CSUM] = (w_word_cnt >= 16'd3) && (r_last_word != r_sum_prev);
    w_err_code[ERR_SEQ]  = (w_word_cnt >= 16'd2) && r_seq_valid && (r_word1 != r_seq_exp);
  end

  upp_sat_cnt #(.WIDTH(16)) u_word_cnt (
    .iCLK     (iCLK),
    .iRESET_N (iRESET_N),
    .iCLR     (w_start),
    .iINC     (w_start || w_capture),
    .oQ       (w_word_cnt)
  );

  upp_sat_cnt #(.WIDTH(16)) u_err_cnt (
    .iCLK     (iCLK),
    .iRESET_N (iRESET_N),
    .iCLR     (1'b0),
    .iINC     (w_eval && (w_err_code != 4'b0000)),
    .oQ       (oERR_CNT)
  );

  // Silence is only measured outside a frame; a frame start restarts it.
  upp_sat_cnt #(.WIDTH(32), .MAX(TIMEOUT_CYC)) u_to_cnt (
    .iCLK     (iCLK),
    .iRESET_N (iRESET_N),
    .iCLR     (w_start),
    .iINC     ((r_state != RUN) && !w_start),
    .oQ       (w_to_cnt)
  );

  always_ff @(posedge iCLK) begin
    if (!iRESET_N) begin
      r_word0     <= '0;
      r_word1     <= '0;
      r_sum       <= '0;
      r_sum_prev  <= '0;
      r_last_word <= '0;
      r_seq_exp   <= '0;
      r_seq_valid <= 1'b0;
      r_frame_ok  <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= '0;
      r_last_len  <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_start) begin
        r_word0     <= iDATA_UPP;
        r_sum       <= iDATA_UPP;
        r_sum_prev  <= '0;
        r_last_word <= iDATA_UPP;
      end else if (w_capture) begin
        if (w_word_cnt == 16'd1) r_word1 <= iDATA_UPP;
        r_sum_prev  <= r_sum;
        r_sum       <= r_sum + iDATA_UPP;
        r_last_word <= iDATA_UPP;
      end

      r_frame_ok  <= w_eval && (w_err_code == 4'b0000);
      r_frame_err <= w_eval && (w_err_code != 4'b0000);

      if (w_eval) begin
        r_err_code  <= w_err_code;
        r_last_len  <= w_word_cnt;
        r_frame_cnt <= r_frame_cnt + 16'd1;
        // Resynchronise on every frame long enough to carry a sequence word.
        if (w_word_cnt >= 16'd2) begin
          r_seq_exp   <= r_word1 + 16'd1;
          r_seq_valid <= 1'b1;
        end
      end
    end
  end

  assign oFRAME_OK  = r_frame_ok;
  assign oFRAME_ERR = r_frame_err;
  assign oERR_CODE  = r_err_code;
  assign oLAST_LEN  = r_last_len;
  assign oFRAME_CNT = r_frame_cnt;
  assign oTIMEOUT   = (w_to_cnt == TIMEOUT_CYC);

endmodule

// File: tb/tb_upp_frame_checker.sv
// Directed bench for upp_frame_checker: good frames, each error class,
// sequence wrap, back-to-back frames, mid-frame reset and link timeout.
module tb_upp_frame_checker;

  logic        iCLK = 1'b0;
  logic        iRESET_N = 1'b0;
  logic [15:0] iDATA_UPP = '0;
  logic        iENA = 1'b0;
  logic        oFRAME_OK;
  logic        oFRAME_ERR;
  logic [3:0]  oERR_CODE;
  logic [15:0] oLAST_LEN;
  logic [15:0] oFRAME_CNT;
  logic [15:0] oERR_CNT;
  logic        oTIMEOUT;

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] frm [0:63];
  int          frm_len;
  logic        to_after_start;

  upp_frame_checker #(.TIMEOUT_CYC(32'd100)) dut (
    .iCLK       (iCLK),
    .iRESET_N   (iRESET_N),
    .iDATA_UPP  (iDATA_UPP),
    .iENA       (iENA),
    .oFRAME_OK  (oFRAME_OK),
    .oFRAME_ERR (oFRAME_ERR),
    .oERR_CODE  (oERR_CODE),
    .oLAST_LEN  (oLAST_LEN),
    .oFRAME_CNT (oFRAME_CNT),
    .oERR_CNT   (oERR_CNT),
    .oTIMEOUT   (oTIMEOUT)
  );

  always #5 iCLK = ~iCLK;

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Header, sequence, payload of 0001 words, checksum at the last index.
  task automatic build(input logic [15:0] hdr, input logic [15:0] seq,
                       input int n, input logic [15:0] csum_xor);
    logic [15:0] sum;
    frm[0] = hdr;
    frm[1] = seq;
    for (int i = 2; i < n - 1; i++) frm[i] = 16'h0001;
    sum = '0;
    for (int i = 0; i < n - 1; i++) sum = sum + frm[i];
    frm[n-1] = sum ^ csum_xor;
    frm_len  = n;
  endtask

  // Drives the frame, then one iENA=0 cycle; returns #1 after the result edge.
  task automatic drive_frame();
    for (int i = 0; i < frm_len; i++) begin
      iENA      = 1'b1;
      iDATA_UPP = frm[i];
      tick();
      if (i == 0) to_after_start = oTIMEOUT;
    end
    iENA      = 1'b0;
    iDATA_UPP = '0;
    tick();
  endtask

  task automatic do_reset();
    iENA     = 1'b0;
    iRESET_N = 1'b0;
    tick();
    tick();
    iRESET_N = 1'b1;
  endtask

  initial begin
    // Reset state and timeout
    do_reset();
    iRESET_N = 1'b0;
    check("rst_ok",    {31'd0, oFRAME_OK},  32'd0);
    check("rst_err",   {31'd0, oFRAME_ERR}, 32'd0);
    check("rst_code",  {28'd0, oERR_CODE},  32'd0);
    check("rst_len",   {16'd0, oLAST_LEN},  32'd0);
    check("rst_fcnt",  {16'd0, oFRAME_CNT}, 32'd0);
    check("rst_ecnt",  {16'd0, oERR_CNT},   32'd0);
    check("rst_to",    {31'd0, oTIMEOUT},   32'd0);
    iRESET_N = 1'b1;
    for (int i = 0; i < 99; i++) tick();
    check("to_99", {31'd0, oTIMEOUT}, 32'd0);
    tick();
    check("to_100", {31'd0, oTIMEOUT}, 32'd1);

    // Good frame, checksum F617
    build(16'hF5F5, 16'h0001, 36, 16'h0000);
    check("csum_word", {16'd0, frm[35]}, 32'h0000F617);
    drive_frame();
    check("to_cleared", {31'd0, to_after_start}, 32'd0);
    check("f1_ok",   {31'd0, oFRAME_OK},  32'd1);
    check("f1_err",  {31'd0, oFRAME_ERR}, 32'd0);
    check("f1_code", {28'd0, oERR_CODE},  32'd0);
    check("f1_len",  {16'd0, oLAST_LEN},  32'd36);
    check("f1_fcnt", {16'd0, oFRAME_CNT}, 32'd1);
    tick();
    check("f1_ok_pulse", {31'd0, oFRAME_OK}, 32'd0);
    check("f1_code_hold", {28'd0, oERR_CODE}, 32'd0);

    // Sequence gap 0005 -> 0007, then 0008 resynchronised
    do_reset();
    tick();
    build(16'hF5F5, 16'h0005, 36, 16'h0000);
    drive_frame();
    check("s5_ok", {31'd0, oFRAME_OK}, 32'd1);
    build(16'hF5F5, 16'h0007, 36, 16'h0000);
    drive_frame();
    check("s7_err",  {31'd0, oFRAME_ERR}, 32'd1);
    check("s7_ok",   {31'd0, oFRAME_OK},  32'd0);
    check("s7_code", {28'd0, oERR_CODE},  32'b0010);
    check("s7_ecnt", {16'd0, oERR_CNT},   32'd1);
    build(16'hF5F5, 16'h0008, 36, 16'h0000);
    drive_frame();
    check("s8_ok",   {31'd0, oFRAME_OK},  32'd1);
    check("s8_fcnt", {16'd0, oFRAME_CNT}, 32'd3);
    check("s8_ecnt", {16'd0, oERR_CNT},   32'd1);

    // Length, header and checksum errors (sequence continues 9, A, B)
    build(16'hF5F5, 16'h0009, 37, 16'h0000);
    drive_frame();
    check("len_code", {28'd0, oERR_CODE}, 32'b0100);
    check("len_len",  {16'd0, oLAST_LEN}, 32'd37);
    check("len_err",  {31'd0, oFRAME_ERR}, 32'd1);
    build(16'hF5F4, 16'h000A, 36, 16'h0000);
    drive_frame();
    check("hdr_code", {28'd0, oERR_CODE}, 32'b0001);
    build(16'hF5F5, 16'h000B, 36, 16'h0100);
    drive_frame();
    check("csum_code", {28'd0, oERR_CODE}, 32'b1000);
    check("csum_ecnt", {16'd0, oERR_CNT},  32'd4);
    check("csum_fcnt", {16'd0, oFRAME_CNT}, 32'd6);

    // Sequence wrap with one-cycle gap
    do_reset();
    tick();
    build(16'hF5F5, 16'hFFFF, 36, 16'h0000);
    drive_frame();
    check("wrap1_ok", {31'd0, oFRAME_OK}, 32'd1);
    build(16'hF5F5, 16'h0000, 36, 16'h0000);
    drive_frame();
    check("wrap2_ok",   {31'd0, oFRAME_OK},  32'd1);
    check("wrap2_code", {28'd0, oERR_CODE},  32'd0);
    check("wrap2_fcnt", {16'd0, oFRAME_CNT}, 32'd2);

    // Reset released mid-frame
    build(16'hF5F5, 16'h0050, 36, 16'h0000);
    for (int i = 0; i < 10; i++) begin
      iENA = 1'b1; iDATA_UPP = frm[i]; tick();
    end
    iRESET_N = 1'b0;
    tick();
    iRESET_N = 1'b1;
    for (int i = 11; i < 36; i++) begin
      iENA = 1'b1; iDATA_UPP = frm[i]; tick();
    end
    iENA = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_no_ok",  {31'd0, oFRAME_OK},  32'd0);
      check("mid_no_err", {31'd0, oFRAME_ERR}, 32'd0);
    end
    check("mid_fcnt", {16'd0, oFRAME_CNT}, 32'd0);
    build(16'hF5F5, 16'h1234, 36, 16'h0000);
    drive_frame();
    check("post_ok",   {31'd0, oFRAME_OK},  32'd1);
    check("post_code", {28'd0, oERR_CODE},  32'd0);
    check("post_fcnt", {16'd0, oFRAME_CNT}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
